calendar_date_counter: RTL and testbench

//  Holds the current calendar date (year, month, day, weekday) and advances it by one day per day_tick.

---
 rtl/calendar_date_counter_pkg.sv | 29 ++
 rtl/calendar_date_counter_month_len_lut.sv | 27 ++
 rtl/calendar_date_counter.sv | 128 ++++++++++++
 tb/tb_calendar_date_counter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/calendar_date_counter_pkg.sv
// Shared calendar constants: field widths, month and weekday encodings.
package calendar_defs;

    localparam int MONTH_W = 4;
    localparam int DAY_W   = 5;
    localparam int WDAY_W  = 3;

    localparam logic [MONTH_W-1:0] JAN = 4'd1;
    localparam logic [MONTH_W-1:0] FEB = 4'd2;
    localparam logic [MONTH_W-1:0] MAR = 4'd3;
    localparam logic [MONTH_W-1:0] APR = 4'd4;
    localparam logic [MONTH_W-1:0] MAY = 4'd5;
    localparam logic [MONTH_W-1:0] JUN = 4'd6;
    localparam logic [MONTH_W-1:0] JUL = 4'd7;
    localparam logic [MONTH_W-1:0] AUG = 4'd8;
    localparam logic [MONTH_W-1:0] SEP = 4'd9;
    localparam logic [MONTH_W-1:0] OCT = 4'd10;
    localparam logic [MONTH_W-1:0] NOV = 4'd11;
    localparam logic [MONTH_W-1:0] DEC = 4'd12;

    localparam logic [WDAY_W-1:0] SUN = 3'd0;
    localparam logic [WDAY_W-1:0] MON = 3'd1;
    localparam logic [WDAY_W-1:0] TUE = 3'd2;
    localparam logic [WDAY_W-1:0] WED = 3'd3;
    localparam logic [WDAY_W-1:0] THU = 3'd4;
    localparam logic [WDAY_W-1:0] FRI = 3'd5;
    localparam logic [WDAY_W-1:0] SAT = 3'd6;

endpackage

// File: rtl/calendar_date_counter_month_len_lut.sv
// Combinational month length: 28..31 for valid months, 0 for months 0 and 13..15.
module month_len_lut
    import calendar_defs::*;
#(
    parameter int YEAR_W = 12
) (
    input  logic [YEAR_W-1:0]  year,
    input  logic [MONTH_W-1:0] month,
    output logic [DAY_W-1:0]   len
);

    logic leap;

    // Divisible-by-4 rule only; exact for 1901..2099.
    assign leap = (year[1:0] == 2'b00);

    always_comb begin
        len = '0;
        case (month)
            JAN, MAR, MAY, JUL, AUG, OCT, DEC: len = 5'd31;
            APR, JUN, SEP, NOV:                len = 5'd30;
            FEB:                               len = leap ? 5'd29 : 5'd28;
            default:                           len = '0;
        endcase
    end

endmodule

// File: rtl/calendar_date_counter.sv
// Calendar date register: advances one day per day_tick, loadable via a validated set port.
module calendar_date_counter
    import calendar_defs::*;
#(
    parameter int YEAR_W    = 12,
    parameter int RST_YEAR  = 2015,
    parameter int RST_MONTH = 1,
    parameter int RST_DAY   = 1,
    parameter int RST_WDAY  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               day_tick,
    input  logic               set_valid,
    input  logic [YEAR_W-1:0]  set_year,
    input  logic [MONTH_W-1:0] set_month,
    input  logic [DAY_W-1:0]   set_day,
    input  logic [WDAY_W-1:0]  set_wday,
    output logic               set_ack,
    output logic               set_err,
    output logic [YEAR_W-1:0]  year,
    output logic [MONTH_W-1:0] month,
    output logic [DAY_W-1:0]   day,
    output logic [WDAY_W-1:0]  wday,
    output logic               month_wrap,
    output logic               year_wrap
);

    logic [YEAR_W-1:0]  year_q, year_d;
    logic [MONTH_W-1:0] month_q, month_d;
    logic [DAY_W-1:0]   day_q, day_d;
    logic [WDAY_W-1:0]  wday_q, wday_d;
    logic               set_ack_q, set_ack_d;
    logic               set_err_q, set_err_d;
    logic               month_wrap_q, month_wrap_d;
    logic               year_wrap_q, year_wrap_d;

    logic [DAY_W-1:0]   cur_len;
    logic [DAY_W-1:0]   set_len;
    logic               set_legal;

    month_len_lut #(.YEAR_W(YEAR_W)) u_cur_len (
        .year  (year_q),
        .month (month_q),
        .len   (cur_len)
    );

    month_len_lut #(.YEAR_W(YEAR_W)) u_set_len (
        .year  (set_year),
        .month (set_month),
        .len   (set_len)
    );

    // An illegal month yields set_len==0, which the day range check rejects on its own.
    assign set_legal = (set_day != '0) && (set_day <= set_len) && (set_wday <= SAT);

    // set_valid is a one-cycle request with no back-pressure: it is always answered on the
    // following cycle by exactly one of set_ack or set_err, and it overrides a same-cycle day_tick.
    always_comb begin
        year_d       = year_q;
        month_d      = month_q;
        day_d        = day_q;
        wday_d       = wday_q;
        set_ack_d    = 1'b0;
        set_err_d    = 1'b0;
        month_wrap_d = 1'b0;
        year_wrap_d  = 1'b0;

        if (set_valid) begin
            if (set_legal) begin
                year_d    = set_year;
                month_d   = set_month;
                day_d     = set_day;
                wday_d    = set_wday;
                set_ack_d = 1'b1;
            end else begin
                set_err_d = 1'b1;
            end
        end else if (day_tick) begin
            wday_d = (wday_q == SAT) ? SUN : wday_q + 1'b1;
            if (day_q < cur_len) begin
                day_d = day_q + 1'b1;
            end else begin
                day_d        = 5'd1;
                month_wrap_d = 1'b1;
                if (month_q == DEC) begin
                    month_d     = JAN;
                    year_d      = year_q + 1'b1;
                    year_wrap_d = 1'b1;
                end else begin
                    month_d = month_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            year_q       <= YEAR_W'(RST_YEAR);
            month_q      <= MONTH_W'(RST_MONTH);
            day_q        <= DAY_W'(RST_DAY);
            wday_q       <= WDAY_W'(RST_WDAY);
            set_ack_q    <= 1'b0;
            set_err_q    <= 1'b0;
            month_wrap_q <= 1'b0;
            year_wrap_q  <= 1'b0;
        end else begin
            year_q       <= year_d;
            month_q      <= month_d;
            day_q        <= day_d;
            wday_q       <= wday_d;
            set_ack_q    <= set_ack_d;
            set_err_q    <= set_err_d;
            month_wrap_q <= month_wrap_d;
            year_wrap_q  <= year_wrap_d;
        end
    end

    assign year       = year_q;
    assign month      = month_q;
    assign day        = day_q;
    assign wday       = wday_q;
    assign set_ack    = set_ack_q;
    assign set_err    = set_err_q;
    assign month_wrap = month_wrap_q;
    assign year_wrap  = year_wrap_q;

endmodule

// File: tb/tb_calendar_date_counter.sv
// Bench for calendar_date_counter: directed scenarios plus random ticks/sets against a date model.
module tb_calendar_date_counter;

    logic        clk;
    logic        rst;
    logic        day_tick;
    logic        set_valid;
    logic [11:0] set_year;
    logic [3:0]  set_month;
    logic [4:0]  set_day;
    logic [2:0]  set_wday;
    logic        set_ack;
    logic        set_err;
    logic [11:0] year;
    logic [3:0]  month;
    logic [4:0]  day;
    logic [2:0]  wday;
    logic        month_wrap;
    logic        year_wrap;

    int errors = 0;
    int checks = 0;

    // Reference date and expected pulses
    int m_year, m_month, m_day, m_wday;
    bit m_ack, m_err, m_mwrap, m_ywrap;

    calendar_date_counter dut (
        .clk        (clk),
        .rst        (rst),
        .day_tick   (day_tick),
        .set_valid  (set_valid),
        .set_year   (set_year),
        .set_month  (set_month),
        .set_day    (set_day),
        .set_wday   (set_wday),
        .set_ack    (set_ack),
        .set_err    (set_err),
        .year       (year),
        .month      (month),
        .day        (day),
        .wday       (wday),
        .month_wrap (month_wrap),
        .year_wrap  (year_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int days_in(input int y, input int m);
        int tbl[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        if (m < 1 || m > 12) return 0;
        if (m == 2 && (y % 4) == 0) return 29;
        return tbl[m-1];
    endfunction

    task automatic model_step(input bit r, input bit t, input bit sv,
                              input int y, input int m, input int d, input int w);
        m_ack = 0; m_err = 0; m_mwrap = 0; m_ywrap = 0;
        if (r) begin
            m_year = 2015; m_month = 1; m_day = 1; m_wday = 4;
        end else if (sv) begin
            if (m >= 1 && m <= 12 && d >= 1 && d <= days_in(y, m) && w <= 6) begin
                m_year = y; m_month = m; m_day = d; m_wday = w;
                m_ack = 1;
            end else begin
                m_err = 1;
            end
        end else if (t) begin
            m_wday = (m_wday + 1) % 7;
            m_day  = m_day + 1;
            if (m_day > days_in(m_year, m_month)) begin
                m_day   = 1;
                m_mwrap = 1;
                m_month = m_month + 1;
                if (m_month == 13) begin
                    m_month = 1;
                    m_year  = (m_year + 1) % 4096;
                    m_ywrap = 1;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        checks += 8;
        assert (year === 12'(m_year)) else begin
            errors++; $error("FAIL %s year: got %0d want %0d", tag, year, m_year);
        end
        assert (month === 4'(m_month)) else begin
            errors++; $error("FAIL %s month: got %0d want %0d", tag, month, m_month);
        end
        assert (day === 5'(m_day)) else begin
            errors++; $error("FAIL %s day: got %0d want %0d", tag, day, m_day);
        end
        assert (wday === 3'(m_wday)) else begin
            errors++; $error("FAIL %s wday: got %0d want %0d", tag, wday, m_wday);
        end
        assert (set_ack === m_ack) else begin
            errors++; $error("FAIL %s set_ack: got %b want %b", tag, set_ack, m_ack);
        end
        assert (set_err === m_err) else begin
            errors++; $error("FAIL %s set_err: got %b want %b", tag, set_err, m_err);
        end
        assert (month_wrap === m_mwrap) else begin
            errors++; $error("FAIL %s month_wrap: got %b want %b", tag, month_wrap, m_mwrap);
        end
        assert (year_wrap === m_ywrap) else begin
            errors++; $error("FAIL %s year_wrap: got %b want %b", tag, year_wrap, m_ywrap);
        end
    endtask

    // One clock: drive inputs, take the edge, sample 1 time unit later.
    task automatic cyc(input string tag, input bit r, input bit t, input bit sv,
                       input int y, input int m, input int d, input int w);
        rst       = r;
        day_tick  = t;
        set_valid = sv;
        set_year  = 12'(y);
        set_month = 4'(m);
        set_day   = 5'(d);
        set_wday  = 3'(w);
        @(posedge clk);
        #1;
        rst = 0; day_tick = 0; set_valid = 0;
        model_step(r, t, sv, y, m, d, w);
        check_all(tag);
    endtask

    task automatic tick(input string tag);
        cyc(tag, 0, 1, 0, 0, 0, 0, 0);
    endtask

    task automatic idle(input string tag);
        cyc(tag, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic set_date(input string tag, input int y, input int m, input int d, input int w);
        cyc(tag, 0, 0, 1, y, m, d, w);
    endtask

    initial begin
        rst = 1; day_tick = 0; set_valid = 0;
        set_year = '0; set_month = '0; set_day = '0; set_wday = '0;
        m_year = 0; m_month = 0; m_day = 0; m_wday = 0;
        m_ack = 0; m_err = 0; m_mwrap = 0; m_ywrap = 0;

        // Reset state, with explicit constants as well as the model
        cyc("reset0", 1, 0, 0, 0, 0, 0, 0);
        cyc("reset1", 1, 0, 0, 0, 0, 0, 0);
        checks++;
        assert (year === 12'd2015 && month === 4'd1 && day === 5'd1 && wday === 3'd4) else begin
            errors++; $error("FAIL reset_const: got %0d-%0d-%0d wd%0d want 2015-1-1 wd4",
                             year, month, day, wday);
        end
        idle("reset_idle");

        // Month end 31 -> Feb 1
        set_date("jan31_set", 2015, 1, 31, 6);
        tick("jan31_tick");
        idle("jan31_pulse_drop");

        // Leap February
        set_date("leap_set", 2016, 2, 28, 0);
        tick("leap_tick1");
        tick("leap_tick2");
        idle("leap_idle");

        // Non-leap February, then illegal Feb 29
        set_date("feb15_set", 2015, 2, 28, 6);
        tick("feb15_tick");
        set_date("feb29_bad", 2015, 2, 29, 0);
        idle("feb29_idle");

        // Other illegal requests
        set_date("bad_month0", 2015, 0, 1, 0);
        set_date("bad_month13", 2015, 13, 1, 0);
        set_date("bad_day0", 2015, 3, 0, 0);
        set_date("bad_apr31", 2015, 4, 31, 0);
        set_date("bad_wday7", 2015, 3, 1, 7);

        // Year end
        set_date("dec31_set", 2015, 12, 31, 4);
        tick("dec31_tick");
        idle("dec31_idle");

        // Year register wrap
        set_date("y4095_set", 4095, 12, 31, 2);
        tick("y4095_tick");

        // Set beats tick; reset beats set
        cyc("set_and_tick", 0, 1, 1, 2020, 6, 15, 1);
        idle("set_and_tick_idle");
        cyc("rst_set_tick", 1, 1, 1, 2020, 6, 15, 1);
        idle("rst_idle");

        // Back-to-back ticks across a 30-day month
        set_date("apr_set", 2021, 4, 29, 4);
        for (int i = 0; i < 4; i++) tick("b2b_tick");

        // Randomized mix
        for (int i = 0; i < 3000; i++) begin
            int r;
            int ry, rm, rd;
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                cyc("rnd_rst", 1, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                    int'($urandom_range(0, 4095)), 1, 1, 0);
            end else if (r < 10) begin
                cyc("rnd_set", 0, bit'($urandom_range(0, 1)), 1,
                    int'($urandom_range(0, 4095)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 31)), int'($urandom_range(0, 7)));
            end else if (r < 14) begin
                ry = (r == 13) ? 4095 : int'($urandom_range(0, 4095));
                rm = int'($urandom_range(1, 12));
                rd = days_in(ry, rm) - int'($urandom_range(0, 1));
                cyc("rnd_set_edge", 0, 0, 1, ry, rm, rd, int'($urandom_range(0, 6)));
            end else begin
                cyc("rnd_tick", 0, ($urandom_range(0, 3) != 0), 0, 0, 0, 0, 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
